// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  // Controller states: waiting, shifting bits, presenting the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default operand/result width
  localparam int SUB_WIDTH_DEF = 4;

  // Signed overflow of a - b: operands of differing sign and a result
  // whose sign differs from the minuend.
  function automatic logic sub_ovf(input logic a_sign,
                                   input logic b_sign,
                                   input logic d_sign);
    return (a_sign != b_sign) && (d_sign != a_sign);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: difference and borrow for a single bit position.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic dif,
  output logic bo
);

  assign dif = x ^ y ^ bi;
  assign bo  = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - b_in (mod 2^N), one bit per clock,
// LSB first. The optional signed-overflow output ovf and its sign-capture
// registers are built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = SUB_WIDTH_DEF
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic [N-1:0] d,
  output logic         b_out,
  output logic         busy,
  output logic         done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  // Counter runs 0..N: N shift edges, then one edge to publish the result.
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [N-1:0]  a_q;
  logic [N-1:0]  a_d;
  logic [N-1:0]  b_q;
  logic [N-1:0]  b_d;
  logic [N-1:0]  res_q;
  logic [N-1:0]  res_d;
  logic          br_q;
  logic          br_d;
  logic [N-1:0]  d_q;
  logic          b_out_q;
  logic          busy_q;
  logic          done_q;
  logic          dif_s;
  logic          bo_s;
  logic          accept_s;

`ifdef SERIAL_SUB_OVF_EN
  logic a_sign_q;
  logic b_sign_q;
  logic ovf_q;
`endif

  fs_cell u_fs_cell (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .bi  (br_q),
    .dif (dif_s),
    .bo  (bo_s)
  );

  // A start is honoured in IDLE and in DONE; it is ignored during RUN.
  assign accept_s = start && ((state_q == IDLE) || (state_q == DONE));

  // Next values for one shift step: operands move right, new bit enters result MSB.
  always_comb begin
    a_d   = {1'b0, a_q[N-1:1]};
    b_d   = {1'b0, b_q[N-1:1]};
    res_d = {dif_s, res_q[N-1:1]};
    br_d  = bo_s;
    cnt_d = cnt_q + CW'(1);
  end

  // Controller FSM with datapath registers and registered outputs.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      a_q      <= {N{1'b0}};
      b_q      <= {N{1'b0}};
      res_q    <= {N{1'b0}};
      br_q     <= 1'b0;
      d_q      <= {N{1'b0}};
      b_out_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else if (accept_s) begin
      state_q  <= RUN;
      cnt_q    <= {CW{1'b0}};
      a_q      <= a;
      b_q      <= b;
      br_q     <= b_in;
      res_q    <= {N{1'b0}};
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_sign_q <= a[N-1];
      b_sign_q <= b[N-1];
`endif
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            // All N bits shifted: publish the result and pulse done.
            state_q <= DONE;
            d_q     <= res_q;
            b_out_q <= br_q;
            done_q  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= sub_ovf(a_sign_q, b_sign_q, res_q[N-1]);
`endif
          end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
            br_q  <= br_d;
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign d     = d_q;
  assign b_out = b_out_q;
  assign busy  = busy_q;
  assign done  = done_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule
